// File: rtl/fp_result_checker_if.sv
// fp_result_checker_if
//   Bundles the vector-source handshake and the fp_unit result port that the
//   in-order result checker sits between.
//   master : the side that supplies expectations and fp_unit completions
//            (bench or self-test sequencer).
//   slave  : the checker itself; it answers with vec_ready and issue.
//   Signals:
//     vec_valid/vec_ready  expectation handshake
//     vec_result/flags     expected result (64) and flags (5)
//     vec_fmt              0 single, anything else double
//     vec_f2i              op is fcvt_f2i, forces an exact compare
//     issue                accept strobe, drives the fp_unit enable
//     dut_ready            fp_unit result valid
//     dut_result/flags     fp_unit result (64) and flags (5)
interface fp_result_checker_if;
    logic        vec_valid;
    logic        vec_ready;
    logic [63:0] vec_result;
    logic [4:0]  vec_flags;
    logic [1:0]  vec_fmt;
    logic        vec_f2i;
    logic        issue;
    logic        dut_ready;
    logic [63:0] dut_result;
    logic [4:0]  dut_flags;

    modport master (
        output vec_valid, vec_result, vec_flags, vec_fmt, vec_f2i,
        output dut_ready, dut_result, dut_flags,
        input  vec_ready, issue
    );

    modport slave (
        input  vec_valid, vec_result, vec_flags, vec_fmt, vec_f2i,
        input  dut_ready, dut_result, dut_flags,
        output vec_ready, issue
    );
endinterface

// File: rtl/fp_result_checker.sv
// fp_result_checker
//   In-order checker for fp_unit completions. Up to DEPTH expectations are
//   queued as they are issued; every fp_unit completion is compared against
//   the oldest one, with optional canonical-NaN masking, and pass/fail
//   statistics are kept. A mismatch (STOP_ON_FAIL=1) or a completion with
//   nothing outstanding stops the checker until reset.
//   Ports:
//     clock, reset   clock and synchronous active-low reset
//     bus            expectation handshake + fp_unit result (slave side)
//     chk_valid      1-cycle pulse, compare result below is fresh
//     mismatch       compare failed (qualified by chk_valid)
//     result_diff    masked result XOR of the last compare
//     flags_diff     flags XOR of the last compare
//     underflow      sticky: completion seen with no pending entry
//     halted         checker stopped
//     pending        number of outstanding expectations
//     pass_count     passed compares (saturating)
//     fail_count     failed compares (saturating)
module fp_result_checker #(
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 32,
    parameter bit STOP_ON_FAIL = 1'b1,
    parameter bit NAN_RELAX    = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    fp_result_checker_if.slave     bus,
    output logic                   chk_valid,
    output logic                   mismatch,
    output logic [63:0]            result_diff,
    output logic [4:0]             flags_diff,
    output logic                   underflow,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] pending,
    output logic [CNT_W-1:0]       pass_count,
    output logic [CNT_W-1:0]       fail_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // One queue entry: {f2i, fmt, flags, result}
    typedef struct packed {
        logic        f2i;
        logic [1:0]  fmt;
        logic [4:0]  flags;
        logic [63:0] result;
    } entry_t;

    entry_t entry_mem [DEPTH];

    state_t           state_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             chk_valid_reg;
    logic             mismatch_reg;
    logic [63:0]      result_diff_reg;
    logic [4:0]       flags_diff_reg;
    logic             underflow_reg;
    logic [CNT_W-1:0] pass_count_reg;
    logic [CNT_W-1:0] fail_count_reg;

    logic             can_push;
    logic             push;
    logic             pop;
    logic             under_evt;
    entry_t           head;
    logic [63:0]      diff_next;
    logic [4:0]       fdiff_next;
    logic             mm_next;

    always_comb begin
        // Readiness looks only at registered state, so a pop on a full
        // queue cannot open a slot for a push in the same cycle.
        can_push   = reset && (state_reg == ST_RUN) && (count_reg < DEPTH_CNT);
        push       = bus.vec_valid && can_push;
        pop        = bus.dut_ready && (state_reg == ST_RUN) && (count_reg != '0);
        under_evt  = bus.dut_ready && (state_reg == ST_RUN) && (count_reg == '0);
        head       = entry_mem[rd_ptr_reg];

        // A canonical NaN from the DUT only has to agree with the expected
        // value on the exponent and quiet bit; the payload is free. fcvt_f2i
        // produces integers, so it is always compared exactly.
        if (NAN_RELAX && !head.f2i && (head.fmt == 2'd0)
                && (bus.dut_result[31:0] == 32'h7FC0_0000)) begin
            diff_next = {32'h0, 1'b0,
                         bus.dut_result[30:22] ^ head.result[30:22], 22'h0};
        end else if (NAN_RELAX && !head.f2i && (head.fmt != 2'd0)
                && (bus.dut_result == 64'h7FF8_0000_0000_0000)) begin
            diff_next = {1'b0, bus.dut_result[62:51] ^ head.result[62:51], 51'h0};
        end else begin
            diff_next = bus.dut_result ^ head.result;
        end
        fdiff_next = bus.dut_flags ^ head.flags;
        mm_next    = (diff_next != '0) || (fdiff_next != '0);

        unique case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Queue storage; no reset needed, occupancy decides what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            entry_mem[wr_ptr_reg] <= '{f2i:    bus.vec_f2i,
                                       fmt:    bus.vec_fmt,
                                       flags:  bus.vec_flags,
                                       result: bus.vec_result};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= ST_RUN;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            chk_valid_reg   <= 1'b0;
            mismatch_reg    <= 1'b0;
            result_diff_reg <= '0;
            flags_diff_reg  <= '0;
            underflow_reg   <= 1'b0;
            pass_count_reg  <= '0;
            fail_count_reg  <= '0;
        end else begin
            chk_valid_reg <= 1'b0;
            count_reg     <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg      <= rd_ptr_reg + 1'b1;
                chk_valid_reg   <= 1'b1;
                mismatch_reg    <= mm_next;
                result_diff_reg <= diff_next;
                flags_diff_reg  <= fdiff_next;
                if (mm_next) begin
                    if (fail_count_reg != '1) begin
                        fail_count_reg <= fail_count_reg + 1'b1;
                    end
                    // Halt lands together with chk_valid so the failing
                    // compare is the last thing the checker reports.
                    if (STOP_ON_FAIL) begin
                        state_reg <= ST_HALT;
                    end
                end else if (pass_count_reg != '1) begin
                    pass_count_reg <= pass_count_reg + 1'b1;
                end
            end
            if (under_evt) begin
                underflow_reg <= 1'b1;
                state_reg     <= ST_HALT;
            end
        end
    end

    assign bus.vec_ready = can_push;
    assign bus.issue     = push;
    assign chk_valid     = chk_valid_reg;
    assign mismatch      = mismatch_reg;
    assign result_diff   = result_diff_reg;
    assign flags_diff    = flags_diff_reg;
    assign underflow     = underflow_reg;
    assign halted        = (state_reg == ST_HALT);
    assign pending       = count_reg;
    assign pass_count    = pass_count_reg;
    assign fail_count    = fail_count_reg;

endmodule

// File: tb/tb_fp_result_checker.sv
// tb_fp_result_checker
//   Two checkers: dut0 (STOP_ON_FAIL=1, 32-bit counters) and dut1
//   (STOP_ON_FAIL=0, 4-bit counters so saturation is reachable). Only the
//   one selected by sel receives handshakes; the other sits idle. A
//   queue-based reference model predicts every output each cycle.
module tb_fp_result_checker;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b0;
    logic sel   = 1'b0;

    logic        vv    = 1'b0;
    logic [63:0] vres  = '0;
    logic [4:0]  vflg  = '0;
    logic [1:0]  vfmt  = '0;
    logic        vf2i  = 1'b0;
    logic        dr    = 1'b0;
    logic [63:0] dres  = '0;
    logic [4:0]  dflg  = '0;

    fp_result_checker_if if0();
    fp_result_checker_if if1();

    assign if0.vec_valid  = vv & ~sel;
    assign if0.dut_ready  = dr & ~sel;
    assign if0.vec_result = vres;
    assign if0.vec_flags  = vflg;
    assign if0.vec_fmt    = vfmt;
    assign if0.vec_f2i    = vf2i;
    assign if0.dut_result = dres;
    assign if0.dut_flags  = dflg;

    assign if1.vec_valid  = vv & sel;
    assign if1.dut_ready  = dr & sel;
    assign if1.vec_result = vres;
    assign if1.vec_flags  = vflg;
    assign if1.vec_fmt    = vfmt;
    assign if1.vec_f2i    = vf2i;
    assign if1.dut_result = dres;
    assign if1.dut_flags  = dflg;

    logic        c0_chk, c0_mm, c0_under, c0_halt;
    logic [63:0] c0_rd;
    logic [4:0]  c0_fd;
    logic [2:0]  c0_pend;
    logic [31:0] c0_pass, c0_fail;
    logic        c1_chk, c1_mm, c1_under, c1_halt;
    logic [63:0] c1_rd;
    logic [4:0]  c1_fd;
    logic [2:0]  c1_pend;
    logic [3:0]  c1_pass, c1_fail;

    fp_result_checker #(.DEPTH(4), .CNT_W(32), .STOP_ON_FAIL(1'b1), .NAN_RELAX(1'b1)) dut0 (
        .clock(clock), .reset(reset), .bus(if0.slave),
        .chk_valid(c0_chk), .mismatch(c0_mm), .result_diff(c0_rd), .flags_diff(c0_fd),
        .underflow(c0_under), .halted(c0_halt), .pending(c0_pend),
        .pass_count(c0_pass), .fail_count(c0_fail)
    );

    fp_result_checker #(.DEPTH(4), .CNT_W(4), .STOP_ON_FAIL(1'b0), .NAN_RELAX(1'b1)) dut1 (
        .clock(clock), .reset(reset), .bus(if1.slave),
        .chk_valid(c1_chk), .mismatch(c1_mm), .result_diff(c1_rd), .flags_diff(c1_fd),
        .underflow(c1_under), .halted(c1_halt), .pending(c1_pend),
        .pass_count(c1_pass), .fail_count(c1_fail)
    );

    logic        o_ready, o_issue, o_chk, o_mm, o_under, o_halt;
    logic [63:0] o_rd, o_pass, o_fail;
    logic [4:0]  o_fd;
    logic [2:0]  o_pend;

    always_comb begin
        o_ready = sel ? if1.vec_ready : if0.vec_ready;
        o_issue = sel ? if1.issue     : if0.issue;
        o_chk   = sel ? c1_chk   : c0_chk;
        o_mm    = sel ? c1_mm    : c0_mm;
        o_under = sel ? c1_under : c0_under;
        o_halt  = sel ? c1_halt  : c0_halt;
        o_rd    = sel ? c1_rd    : c0_rd;
        o_fd    = sel ? c1_fd    : c0_fd;
        o_pend  = sel ? c1_pend  : c0_pend;
        o_pass  = sel ? 64'(c1_pass) : 64'(c0_pass);
        o_fail  = sel ? 64'(c1_fail) : 64'(c0_fail);
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  flg;
        logic [1:0]  fmt;
        logic        f2i;
    } exp_t;

    exp_t              m_q[$];
    bit                m_halt, m_under, m_chk, m_mm, m_stop;
    logic [63:0]       m_rdiff;
    logic [4:0]        m_fdiff;
    longint unsigned   m_pass, m_fail, m_sat;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (dut%0d, t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] r, input logic [4:0] f,
                                input logic [1:0] fm, input logic f2);
        exp_t e;
        e.res = r; e.flg = f; e.fmt = fm; e.f2i = f2;
        return e;
    endfunction

    // Canonical-NaN relaxation expressed as a bit mask over the plain XOR.
    function automatic logic [63:0] ref_diff(input exp_t e, input logic [63:0] r);
        logic [63:0] full;
        full = r ^ e.res;
        if (!e.f2i && e.fmt == 2'd0 && r[31:0] == 32'h7FC0_0000)
            return full & 64'h0000_0000_7FC0_0000;
        if (!e.f2i && e.fmt != 2'd0 && r == 64'h7FF8_0000_0000_0000)
            return full & 64'h7FF8_0000_0000_0000;
        return full;
    endfunction

    task automatic select_dut(input logic s);
        sel    = s;
        m_stop = !s;
        m_sat  = s ? 64'd15 : 64'hFFFF_FFFF;
    endtask

    // One clock: drive at negedge, check handshake, advance model, check
    // registered outputs just after the posedge.
    task automatic step(input logic v, input exp_t ve, input logic d,
                        input logic [63:0] dres_i, input logic [4:0] dflg_i);
        bit   ready_exp, iss;
        exp_t e;
        @(negedge clock);
        vv = v; vres = ve.res; vflg = ve.flg; vfmt = ve.fmt; vf2i = ve.f2i;
        dr = d; dres = dres_i; dflg = dflg_i;
        #1;
        ready_exp = reset && !m_halt && (m_q.size() < 4);
        iss       = v && ready_exp;
        check_eq("vec_ready", 64'(o_ready), 64'(ready_exp));
        check_eq("issue",     64'(o_issue), 64'(iss));
        m_chk = 1'b0;
        if (!reset) begin
            m_q.delete();
            m_halt = 0; m_under = 0; m_mm = 0;
            m_rdiff = '0; m_fdiff = '0; m_pass = 0; m_fail = 0;
        end else begin
            if (d && !m_halt) begin
                if (m_q.size() == 0) begin
                    m_under = 1; m_halt = 1;
                end else begin
                    e       = m_q.pop_front();
                    m_rdiff = ref_diff(e, dres_i);
                    m_fdiff = dflg_i ^ e.flg;
                    m_mm    = (m_rdiff != 0) || (m_fdiff != 0);
                    m_chk   = 1'b1;
                    if (m_mm) begin
                        if (m_fail < m_sat) m_fail++;
                        if (m_stop) m_halt = 1;
                    end else if (m_pass < m_sat) begin
                        m_pass++;
                    end
                    $display("chk dut%0d exp=%h got=%h diff=%h fdiff=%h mm=%0d",
                             sel, e.res, dres_i, m_rdiff, m_fdiff, m_mm);
                end
            end
            if (iss) m_q.push_back(ve);
        end
        @(posedge clock);
        #1;
        check_eq("chk_valid", 64'(o_chk), 64'(m_chk));
        if (m_chk || !reset) check_eq("mismatch", 64'(o_mm), 64'(m_mm));
        check_eq("result_diff", o_rd, m_rdiff);
        check_eq("flags_diff", 64'(o_fd), 64'(m_fdiff));
        check_eq("underflow", 64'(o_under), 64'(m_under));
        check_eq("halted", 64'(o_halt), 64'(m_halt));
        check_eq("pending", 64'(o_pend), 64'(m_q.size()));
        check_eq("pass_count", o_pass, m_pass);
        check_eq("fail_count", o_fail, m_fail);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        reset = 1'b1;
    endtask

    function automatic exp_t rand_vec();
        exp_t e;
        e.fmt = 2'($urandom_range(0, 3));
        e.f2i = ($urandom_range(0, 3) == 0);
        e.flg = 5'($urandom);
        if ($urandom_range(0, 2) == 0) begin
            if (e.fmt == 2'd0)
                e.res = {32'($urandom), (32'h7FC0_0000 | (32'($urandom) & 32'h803F_FFFF))};
            else
                e.res = 64'h7FF8_0000_0000_0000 | ({32'($urandom), 32'($urandom)} & 64'h8007_FFFF_FFFF_FFFF);
        end else begin
            e.res = {32'($urandom), 32'($urandom)};
        end
        if ($urandom_range(0, 1) == 0) e.flg = 5'd0;
        return e;
    endfunction

    task automatic random_phase(input int cycles);
        exp_t        h;
        logic        d;
        logic [63:0] r;
        logic [4:0]  f;
        int          kind;
        for (int c = 0; c < cycles; c++) begin
            reset = !((m_halt && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0);
            r = {32'($urandom), 32'($urandom)};
            f = 5'($urandom);
            if (m_q.size() > 0) begin
                d    = ($urandom_range(0, 2) != 0);
                h    = m_q[0];
                kind = $urandom_range(0, 9);
                r    = h.res;
                f    = h.flg;
                if (kind == 6 || kind == 7) begin
                    if (h.fmt == 2'd0) r = {32'($urandom), 32'h7FC0_0000};
                    else               r = 64'h7FF8_0000_0000_0000;
                end else if (kind == 8) begin
                    r = h.res ^ (64'd1 << $urandom_range(0, 63));
                end else if (kind == 9) begin
                    f = h.flg ^ (5'd1 << $urandom_range(0, 4));
                end
            end else begin
                d = ($urandom_range(0, 39) == 0);
            end
            step(($urandom_range(0, 1) == 1), rand_vec(), d, r, f);
        end
        reset = 1'b1;
    endtask

    initial begin
        select_dut(1'b0);
        m_q.delete();
        m_halt = 0; m_under = 0; m_chk = 0; m_mm = 0;
        m_rdiff = '0; m_fdiff = '0; m_pass = 0; m_fail = 0;

        // Reset held with a vector offered: nothing may be accepted.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, mk(64'h1234, 5'd0, 2'd0, 1'b0), 1'b0, '0, '0);
        reset = 1'b1;

        // Single op, completion three cycles after issue.
        step(1'b1, mk(64'h3F80_0000, 5'd0, 2'd0, 1'b0), 1'b0, '0, '0);
        idle(); idle();
        step(1'b0, '0, 1'b1, 64'h3F80_0000, 5'd0);
        check_eq("single_pass", o_pass, 64'd1);

        // Fill to DEPTH, fifth offer refused; drain with an offer on the full-pop cycle.
        for (int i = 0; i < 5; i++)
            step(1'b1, mk(64'h4000_0000 + 64'(i), 5'd0, 2'd0, 1'b0), 1'b0, '0, '0);
        check_eq("full_pending", 64'(o_pend), 64'd4);
        for (int i = 0; i < 4; i++)
            step((i == 0), mk(64'hDEAD, 5'd0, 2'd0, 1'b0), 1'b1, 64'h4000_0000 + 64'(i), 5'd0);
        check_eq("drain_pending", 64'(o_pend), 64'd0);
        check_eq("drain_pass", o_pass, 64'd5);

        // Single-precision canonical NaN: payload ignored, exponent/quiet bit not.
        step(1'b1, mk(64'h7FC0_0001, 5'd0, 2'd0, 1'b0), 1'b0, '0, '0);
        step(1'b0, '0, 1'b1, 64'h7FC0_0000, 5'd0);
        check_eq("nan_s_diff", o_rd, 64'd0);
        step(1'b1, mk(64'h7F80_0001, 5'd0, 2'd0, 1'b0), 1'b0, '0, '0);
        step(1'b0, '0, 1'b1, 64'h7FC0_0000, 5'd0);
        check_eq("nan_s_bad_diff", o_rd, 64'h0000_0000_0040_0000);
        check_eq("nan_s_bad_halt", 64'(o_halt), 64'd1);
        step(1'b1, mk(64'h1, 5'd0, 2'd0, 1'b0), 1'b1, 64'h5, 5'd0);
        check_eq("halt_ignores", o_fail, 64'd1);
        do_reset();

        // Double: relaxed pass, then f2i forced exact.
        step(1'b1, mk(64'h7FF8_0000_0000_1234, 5'd0, 2'd1, 1'b0), 1'b0, '0, '0);
        step(1'b0, '0, 1'b1, 64'h7FF8_0000_0000_0000, 5'd0);
        check_eq("nan_d_diff", o_rd, 64'd0);
        step(1'b1, mk(64'h7FF8_0000_0000_0001, 5'd0, 2'd1, 1'b1), 1'b0, '0, '0);
        step(1'b0, '0, 1'b1, 64'h7FF8_0000_0000_0000, 5'd0);
        check_eq("f2i_diff", o_rd, 64'd1);
        do_reset();

        // Flag mismatch halts.
        step(1'b1, mk(64'h3F80_0000, 5'b00001, 2'd0, 1'b0), 1'b0, '0, '0);
        step(1'b0, '0, 1'b1, 64'h3F80_0000, 5'd0);
        check_eq("flag_fdiff", 64'(o_fd), 64'd1);
        check_eq("flag_fail", o_fail, 64'd1);
        do_reset();

        // Underflow on empty, and on the very cycle of the first push.
        step(1'b0, '0, 1'b1, 64'h0, 5'd0);
        check_eq("uflow_flag", 64'(o_under), 64'd1);
        do_reset();
        step(1'b1, mk(64'h1, 5'd0, 2'd0, 1'b0), 1'b1, 64'h1, 5'd0);
        check_eq("uflow_first", 64'(o_under), 64'd1);
        do_reset();

        // Reset mid-stream with three outstanding.
        for (int i = 0; i < 3; i++) step(1'b1, mk(64'(i), 5'd0, 2'd0, 1'b0), 1'b0, '0, '0);
        check_eq("mid_pending", 64'(o_pend), 64'd3);
        do_reset();
        #1;
        check_eq("ready_after_rst", 64'(o_ready), 64'd1);

        // Continue-on-fail instance.
        select_dut(1'b1);
        do_reset();
        step(1'b1, mk(64'h3F80_0000, 5'b00001, 2'd0, 1'b0), 1'b0, '0, '0);
        step(1'b1, mk(64'h4000_0000, 5'd0, 2'd0, 1'b0), 1'b1, 64'h3F80_0000, 5'd0);
        step(1'b1, mk(64'h4040_0000, 5'd0, 2'd0, 1'b0), 1'b1, 64'h4000_0000, 5'd0);
        step(1'b0, '0, 1'b1, 64'h4040_0001, 5'd0);
        check_eq("cont_fail", o_fail, 64'd2);
        check_eq("cont_halt", 64'(o_halt), 64'd0);

        // Randomized traffic on both instances.
        select_dut(1'b0);
        do_reset();
        random_phase(800);
        select_dut(1'b1);
        do_reset();
        random_phase(800);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
